// File: rtl/regfile_sb_pkg.sv
// Shared types and constants for the decode-stage register file and its
// pending-write scoreboard.
package regfile_sb_pkg;

  localparam int DEF_XLEN     = 32;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_AW       = $clog2(DEF_NUM_REGS);

  typedef logic [DEF_AW-1:0] reg_addr_t;

  // Writeback request as it leaves the WB stage.
  typedef struct packed {
    logic                en;
    reg_addr_t           dest;
    logic [DEF_XLEN-1:0] data;
  } wb_req_t;

  // Largest value a pending-write counter of the given width can hold.
  function automatic int unsigned pend_cap(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/id_regfile_sb_if.sv
// Operand-read, issue and writeback bundle between ID control and the
// register file scoreboard.
interface id_regfile_sb_if #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_READ = 2
);
    localparam int AW = $clog2(NUM_REGS);

    logic [NUM_READ*AW-1:0]   rd_addr;
    logic [NUM_READ*XLEN-1:0] rd_data;
    logic [NUM_READ-1:0]      rd_busy;
    logic                     issue_en;
    logic [AW-1:0]            issue_dest;
    logic                     issue_ready;
    logic                     wb_en;
    logic [AW-1:0]            wb_dest;
    logic [XLEN-1:0]          wb_data;
    logic                     flush;

    modport master (
        output rd_addr, issue_en, issue_dest, wb_en, wb_dest, wb_data, flush,
        input  rd_data, rd_busy, issue_ready
    );

    modport slave (
        input  rd_addr, issue_en, issue_dest, wb_en, wb_dest, wb_data, flush,
        output rd_data, rd_busy, issue_ready
    );

endinterface

// File: rtl/sb_counter_bank.sv
// Per-register saturating pending-write counters; register 0 never counts.
module sb_counter_bank
    import regfile_sb_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int PEND_W   = 2,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             inc_en,
    input  logic [AW-1:0]                    inc_idx,
    input  logic                             dec_en,
    input  logic [AW-1:0]                    dec_idx,
    output logic [NUM_REGS-1:0][PEND_W-1:0]  cnt
);

    localparam logic [PEND_W-1:0] CNT_MAX = PEND_W'(pend_cap(PEND_W));

    logic [NUM_REGS-1:0] inc;
    logic [NUM_REGS-1:0] dec;

    // NOTE: every always_comb output gets a default first so no path
    // through the block can leave it unassigned and infer a latch.
    always_comb begin
        inc = '0;
        dec = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            inc[r] = inc_en && (inc_idx == AW'(r));
            dec[r] = dec_en && (dec_idx == AW'(r)) && (cnt[r] != '0);
        end
    end

    // NOTE: state registers use non-blocking assignments so every counter
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            cnt <= '0;
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (inc[r] && !dec[r] && (cnt[r] != CNT_MAX))
                    cnt[r] <= cnt[r] + PEND_W'(1);
                else if (dec[r] && !inc[r])
                    cnt[r] <= cnt[r] - PEND_W'(1);
            end
        end
    end

endmodule

// File: rtl/id_regfile_sb.sv
// ID-stage register file with optional writeback bypass and a pending-write
// scoreboard that reports operand busy status for hazard stalls.
module id_regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int XLEN     = DEF_XLEN,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_READ = 2,
    parameter bit BYPASS   = 1'b1,
    parameter int PEND_W   = 2
) (
    input  logic            clk,
    input  logic            rst,
    id_regfile_sb_if.slave  bus
);

    localparam int AW = $clog2(NUM_REGS);
    localparam logic [PEND_W-1:0] CNT_MAX = PEND_W'(pend_cap(PEND_W));

    logic [XLEN-1:0]                   regs [NUM_REGS];
    logic [NUM_REGS-1:0][PEND_W-1:0]   cnt;
    logic [NUM_READ-1:0][AW-1:0]       raddr;
    logic [NUM_READ-1:0][XLEN-1:0]     rdata;
    logic [NUM_READ-1:0]               rbusy;
    logic [NUM_READ-1:0]               byp;
    logic                              wb_hit;
    logic                              issue_ready;
    logic                              accept;

    assign wb_hit = bus.wb_en && (bus.wb_dest != '0);

    // NOTE: the array is reset explicitly because reads straight after reset
    // must return zero; this makes it flops rather than a RAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
        end else if (wb_hit) begin
            regs[bus.wb_dest] <= bus.wb_data;
        end
    end

    assign raddr = bus.rd_addr;

    // A same-cycle writeback retires one pending count as seen by the reader.
    always_comb begin
        rdata = '0;
        rbusy = '0;
        byp   = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            if (raddr[i] != '0) begin
                byp[i]   = BYPASS && bus.wb_en && (bus.wb_dest == raddr[i]);
                rdata[i] = byp[i] ? bus.wb_data : regs[raddr[i]];
                rbusy[i] = cnt[raddr[i]] > PEND_W'(byp[i]);
            end
        end
    end

    assign bus.rd_data = rdata;
    assign bus.rd_busy = rbusy;

    assign issue_ready = (bus.issue_dest == '0)
                      || (cnt[bus.issue_dest] != CNT_MAX)
                      || (bus.wb_en && (bus.wb_dest == bus.issue_dest));
    assign accept      = bus.issue_en && issue_ready;
    assign bus.issue_ready = issue_ready;

    sb_counter_bank #(
        .NUM_REGS (NUM_REGS),
        .PEND_W   (PEND_W),
        .AW       (AW)
    ) u_counters (
        .clk     (clk),
        .rst     (rst),
        .flush   (bus.flush),
        .inc_en  (accept && (bus.issue_dest != '0)),
        .inc_idx (bus.issue_dest),
        .dec_en  (wb_hit),
        .dec_idx (bus.wb_dest),
        .cnt     (cnt)
    );

endmodule

// File: tb/tb_id_regfile_sb.sv
// Directed self-checking bench for id_regfile_sb: bypass, register 0,
// counter saturation, simultaneous issue/wb, flush and mid-run reset.
module tb_id_regfile_sb;
    import regfile_sb_pkg::*;

    localparam int XLEN     = 32;
    localparam int NUM_REGS = 32;
    localparam int NUM_READ = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    id_regfile_sb_if #(.XLEN(XLEN), .NUM_REGS(NUM_REGS), .NUM_READ(NUM_READ)) bus ();

    id_regfile_sb #(
        .XLEN     (XLEN),
        .NUM_REGS (NUM_REGS),
        .NUM_READ (NUM_READ),
        .BYPASS   (1'b1),
        .PEND_W   (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rdp(input int i);
        return bus.rd_data[i*XLEN +: XLEN];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input reg_addr_t a2, input reg_addr_t a1, input reg_addr_t a0);
        bus.rd_addr = {a2, a1, a0};
    endtask

    task automatic drive_wb(input wb_req_t w);
        bus.wb_en   = w.en;
        bus.wb_dest = w.dest;
        bus.wb_data = w.data;
    endtask

    task automatic issue(input logic en, input reg_addr_t d);
        bus.issue_en   = en;
        bus.issue_dest = d;
    endtask

    task automatic idle();
        issue(1'b0, 5'd0);
        drive_wb('{en: 1'b0, dest: 5'd0, data: 32'h0});
        bus.flush = 1'b0;
    endtask

    initial begin
        idle();
        set_rd(5'd0, 5'd0, 5'd0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        set_rd(5'd5, 5'd5, 5'd5);
        issue(1'b0, 5'd7);
        #1;
        check("rst_data",  rdp(0), 32'h0);
        check("rst_busy",  32'(bus.rd_busy), 32'h0);
        check("rst_ready", 32'(bus.issue_ready), 32'h1);

        // 1: write x5, same-cycle bypass then array read
        drive_wb('{en: 1'b1, dest: 5'd5, data: 32'hDEADBEEF});
        #1 check("t1_bypass", rdp(0), 32'hDEADBEEF);
        tick();
        idle();
        #1;
        check("t1_array", rdp(0), 32'hDEADBEEF);
        check("t1_busy",  32'(bus.rd_busy), 32'h0);

        // 2: register 0 ignores writes and issue
        set_rd(5'd0, 5'd0, 5'd0);
        drive_wb('{en: 1'b1, dest: 5'd0, data: 32'h1234});
        issue(1'b1, 5'd0);
        #1;
        check("t2_data_same", rdp(0), 32'h0);
        check("t2_busy_same", 32'(bus.rd_busy), 32'h0);
        check("t2_ready",     32'(bus.issue_ready), 32'h1);
        tick();
        idle();
        #1;
        check("t2_data_next", rdp(1), 32'h0);
        check("t2_busy_next", 32'(bus.rd_busy), 32'h0);

        // 3: saturate x7 at 3 pending writes
        set_rd(5'd7, 5'd7, 5'd7);
        issue(1'b1, 5'd7);
        #1 check("t3_busy_pre", 32'(bus.rd_busy), 32'h0);
        tick();                                   // cnt 1
        check("t3_busy_after1", 32'(bus.rd_busy), 32'h7);
        tick();                                   // cnt 2
        tick();                                   // cnt 3
        check("t3_ready_full", 32'(bus.issue_ready), 32'h0);
        tick();                                   // blocked, cnt 3
        check("t3_ready_still", 32'(bus.issue_ready), 32'h0);
        drive_wb('{en: 1'b1, dest: 5'd7, data: 32'h77});
        #1 check("t3_ready_wb", 32'(bus.issue_ready), 32'h1);
        tick();                                   // +1 -1, cnt 3
        issue(1'b0, 5'd0);
        drive_wb('{en: 1'b1, dest: 5'd7, data: 32'h70});
        tick();                                   // cnt 2
        tick();                                   // cnt 1
        idle();
        #1;
        check("t3_busy_cnt1", 32'(bus.rd_busy), 32'h7);
        check("t3_data",      rdp(2), 32'h70);
        drive_wb('{en: 1'b1, dest: 5'd7, data: 32'h71});
        #1 check("t3_busy_bypass", 32'(bus.rd_busy), 32'h0);
        tick();
        idle();
        #1;
        check("t3_busy_clear", 32'(bus.rd_busy), 32'h0);
        check("t3_data_final", rdp(1), 32'h71);

        // 4: issue and wb on x9 in the same cycle with cnt=1
        set_rd(5'd9, 5'd9, 5'd9);
        issue(1'b1, 5'd9);
        tick();                                   // cnt 1
        drive_wb('{en: 1'b1, dest: 5'd9, data: 32'h99});
        #1 check("t4_busy_same", 32'(bus.rd_busy), 32'h0);
        tick();                                   // cnt stays 1
        idle();
        #1;
        check("t4_busy_kept", 32'(bus.rd_busy), 32'h7);
        check("t4_data",      rdp(0), 32'h99);
        drive_wb('{en: 1'b1, dest: 5'd9, data: 32'h9A});
        #1;
        check("t4_busy_wb",   32'(bus.rd_busy), 32'h0);
        check("t4_data_byp",  rdp(0), 32'h9A);
        tick();
        idle();
        #1 check("t4_busy_done", 32'(bus.rd_busy), 32'h0);

        // 5: flush with concurrent wb and issue
        issue(1'b1, 5'd3);
        tick();
        issue(1'b1, 5'd4);
        tick();
        idle();
        set_rd(5'd10, 5'd4, 5'd3);
        #1 check("t5_busy_pre", 32'(bus.rd_busy), 32'h3);
        bus.flush = 1'b1;
        drive_wb('{en: 1'b1, dest: 5'd3, data: 32'h55});
        issue(1'b1, 5'd10);
        tick();
        idle();
        #1;
        check("t5_busy_flushed", 32'(bus.rd_busy), 32'h0);
        check("t5_data_x3",      rdp(0), 32'h55);

        // 6: three ports on x12 with bypass, then mid-run reset
        set_rd(5'd12, 5'd12, 5'd12);
        issue(1'b1, 5'd12);
        tick();
        tick();                                   // cnt 2
        idle();
        drive_wb('{en: 1'b1, dest: 5'd12, data: 32'hA5});
        #1;
        for (int i = 0; i < NUM_READ; i++) check($sformatf("t6_data_p%0d", i), rdp(i), 32'hA5);
        check("t6_busy_all", 32'(bus.rd_busy), 32'h7);
        tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        issue(1'b0, 5'd12);
        #1;
        for (int i = 0; i < NUM_READ; i++) check($sformatf("t6_rst_data_p%0d", i), rdp(i), 32'h0);
        check("t6_rst_busy",  32'(bus.rd_busy), 32'h0);
        check("t6_rst_ready", 32'(bus.issue_ready), 32'h1);
        set_rd(5'd9, 5'd7, 5'd5);
        #1;
        check("t6_rst_x5", rdp(0), 32'h0);
        check("t6_rst_x9", rdp(2), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/id_regfile_sb.md
Name: id_regfile_sb

Overview:
Parametrised decode-stage register file with a per-register pending-write scoreboard.
- Supplies NUM_READ operand read ports with optional same-cycle writeback bypass.
- Tracks in-flight writes per destination register with saturating counters and reports operand busy status for hazard stalling.
- Sits in the ID stage: read addresses come from the IF/ID register, issue info comes from ID control, and writes come from the WB stage.

Parameters:
XLEN, 32, data width in bits
NUM_REGS, 32, number of architectural registers (power of 2; register 0 hardwired to zero)
NUM_READ, 2, number of read ports (1..4)
BYPASS, 1, 1 = writeback data/clear visible to reads in the same cycle; 0 = visible next cycle
PEND_W, 2, width of each pending-write counter (max in-flight writes per register = 2^PEND_W-1)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
rd_addr  in  NUM_READ*AW  packed read addresses, port i at [i*AW +: AW]; AW = $clog2(NUM_REGS)
rd_data  out  NUM_READ*XLEN  packed read data, combinational
rd_busy  out  NUM_READ  1 = operand has an outstanding write, combinational
issue_en  in  1  ID requests to mark issue_dest as pending
issue_dest  in  AW  destination of the issuing instruction
issue_ready  out  1  issue accepted this cycle when issue_en=1
wb_en  in  1  writeback valid
wb_dest  in  AW  writeback destination
wb_data  in  XLEN  writeback value
flush  in  1  squash all in-flight writes (branch mispredict)

Behaviour:
- Reset (synchronous, highest priority): all registers = 0, all counters = 0.
  - Outputs after reset: rd_data = 0, rd_busy = 0, issue_ready = 1.
- Register 0: reads return 0 and busy 0. Writes are ignored. Its counter is never incremented. Issue to register 0 is always ready.
- Write:
  - When wb_en=1 and wb_dest!=0, regs[wb_dest] <= wb_data at the clock edge.
  - Write happens even if the counter is 0 (the stale count is not checked) and even if flush=1 in the same cycle.
- Read port i, addr a != 0:
  - BYPASS=1 and wb_en and wb_dest==a -> rd_data = wb_data; otherwise rd_data = regs[a].
- Busy, with cnt = counter[a]:
  - BYPASS=1: rd_busy = (cnt - (wb_en && wb_dest==a)) != 0.
  - BYPASS=0: rd_busy = cnt != 0.
- issue_ready:
  - 1 if issue_dest==0, or counter[issue_dest] != max, or (wb_en && wb_dest==issue_dest).
  - Ready does not depend on flush.
- Accept = issue_en && issue_ready.
- Counter update per register r, in priority order:
  1. rst
  2. flush: all counters <= 0 (an issue in the same cycle is also discarded)
  3. +1 if accept targets r; -1 if wb targets r and cnt != 0. Both in the same cycle on the same r -> net unchanged.
- Underflow: a wb to a register with cnt = 0 leaves cnt at 0; the data is still written.
- Saturation: the counter never exceeds max because issue_ready blocks the issue.
- Multiple read ports with the same address return identical data and busy.
- Latency:
  - Write-to-array: 1 cycle.
  - Bypass: 0 cycles.
  - Issue-to-busy: 1 cycle (the counter is registered).
- Reset asserted mid-operation discards pending counts and data; no partial updates.

Decomposition:
- Shared package regfile_sb_pkg holds:
  - default XLEN/NUM_REGS constants;
  - typedef reg_addr_t (AW bits);
  - struct wb_req_t {en, dest, data} for connecting WB to ID control words.
- One natural sub-module: sb_counter_bank (NUM_REGS saturating up/down counters with flush).
- Data array and bypass muxes stay in the top level.

Test Plan:
1. Reset, then write x5=0xDEADBEEF via wb; next cycle read port0 addr5 -> 0xDEADBEEF, busy 0. A same-cycle read with BYPASS=1 -> 0xDEADBEEF.
2. Write x0=0x1234, issue_dest=0 -> reads of x0 return 0, busy 0, issue_ready stays 1.
3. Issue to x7 three times (PEND_W=2) -> rd_busy on x7 from the cycle after the first issue. A fourth issue sees issue_ready=0 and the counter stays at 3. A wb to x7 in the same cycle as that fourth issue -> ready=1, count remains 3.
4. Issue x9 and wb x9 in the same cycle with cnt=1 -> cnt stays 1, busy stays 1. Next wb to x9 -> busy 0 (BYPASS=1: during the wb cycle).
5. Pending writes on x3 and x4, assert flush together with a wb to x3=0x55 -> all busy = 0 next cycle, x3 reads 0x55, and an issue in the flush cycle is dropped.
6. NUM_READ=3, all ports addr 12 with a pending write and wb_data=0xA5 arriving -> all ports return 0xA5 and identical busy. Asserting rst mid-sequence -> all data 0, busy 0 next cycle.
